// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC exchange with pc_adder, imem request/response,
// and the valid/ready hand-off to decode.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [1:0]      pc_src;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            fetch_misalign;

  // Fetch unit side
  modport master (
    output pc, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misalign,
    input  next_pc, pc_src, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  // Environment side (pc_adder, imem, decode)
  modport slave (
    input  pc, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misalign,
    output next_pc, pc_src, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps a single imem request in flight, buffers one
// instruction for decode, and squashes stale fetches after a redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing a request for pc
    S_WAIT = 2'd1,  // request accepted, awaiting its response
    S_HOLD = 2'd2,  // instruction buffered for decode
    S_DROP = 2'd3   // awaiting a response that must be discarded
  } state_e;

  localparam logic [1:0] SRC_SEQ   = 2'b00;
  localparam logic [1:0] SRC_BR    = 2'b01;
  localparam logic [1:0] SRC_JALR  = 2'b10;
  localparam logic [1:0] SRC_STALL = 2'b11;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            misalign_q, misalign_d;

  logic stall, redirect, req_valid, req_hs, if_valid, if_hs, rsp;

  assign stall    = (bus.pc_src == SRC_STALL);
  assign redirect = (bus.pc_src == SRC_BR) || (bus.pc_src == SRC_JALR);
  assign rsp      = bus.imem_rsp_valid;

  // rst gating keeps both valids low before the first reset edge too
  assign req_valid = (state_q == S_REQ) && !stall && !rst;
  assign if_valid  = (state_q == S_HOLD) && !stall && !rst;
  assign req_hs    = req_valid && bus.imem_req_ready;
  assign if_hs     = if_valid && bus.if_ready;

  assign bus.pc             = pc_q;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.fetch_misalign = misalign_q;

  // Next-state, PC and buffer update; redirect outranks every other event
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    misalign_d = 1'b0;

    // Redirect target is force-aligned; the dropped low bits raise a one-cycle flag
    if (redirect) begin
      pc_d       = {bus.next_pc[XLEN-1:2], 2'b00};
      misalign_d = |bus.next_pc[1:0];
    end

    unique case (state_q)
      S_REQ: begin
        // A redirect racing an accepted request leaves an old-PC fetch in flight
        if (req_hs) state_d = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_d = rsp ? S_REQ : S_DROP;
        end else if (rsp) begin
          // Capture even under stall; pc is still the address that was fetched
          state_d    = S_HOLD;
          if_instr_d = bus.imem_rsp_data;
          if_pc_d    = pc_q;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (if_hs && bus.pc_src == SRC_SEQ) begin
          state_d = S_REQ;
          pc_d    = bus.next_pc;
        end
      end
      S_DROP: begin
        if (rsp) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // State register with synchronous reset; in-flight responses die with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC[XLEN-1:0];
      if_pc_q    <= '0;
      if_instr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Random-stimulus bench for instr_fetch_unit: a one-outstanding memory with
// 1..3 cycle latency, random pc_src/if_ready/backpressure and occasional resets,
// checked against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NCYC     = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: fetch state as transactions, not as an FSM encoding.
  //   m_out   : a memory request is in flight
  //   m_stale : that request belongs to a PC abandoned by a redirect
  //   m_held  : an instruction is buffered for decode
  logic [31:0] m_pc       = RESET_PC;
  logic [31:0] m_if_pc    = '0;
  logic [31:0] m_if_instr = '0;
  logic        m_mis      = 1'b0;
  bit          m_out      = 0;
  bit          m_stale    = 0;
  bit          m_held     = 0;

  // Memory emulation: one request at a time, response 1..3 cycles later
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_data = '0;

  initial begin
    logic [1:0]  src;
    logic [31:0] npc;
    bit          stall, redir, rsp_fire, rdy, exp_rv, exp_iv;
    int          rst_left;

    rst_left = 0;
    bus.pc_src         = 2'b00;
    bus.next_pc        = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);

      if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 2);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;

      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: src = 2'b00;
        6:                src = 2'b01;
        7:                src = 2'b10;
        default:          src = 2'b11;
      endcase
      if (src == 2'b00) begin
        npc = m_pc + 32'd4;  // what pc_adder would offer
      end else begin
        case ($urandom_range(0, 3))
          0:       npc = $urandom();
          1:       npc = $urandom() & 32'hFFFF_FFFC;
          2:       npc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
          default: npc = $urandom_range(0, 255);
        endcase
      end
      bus.pc_src   = src;
      bus.next_pc  = npc;
      bus.if_ready = ($urandom_range(0, 3) != 0);

      rsp_fire           = mem_busy && (mem_cnt == 0);
      bus.imem_rsp_valid = rsp_fire;
      bus.imem_rsp_data  = rsp_fire ? mem_data : $urandom();
      bus.imem_req_ready = !mem_busy && ($urandom_range(0, 3) != 0);
      #1;

      stall  = (src == 2'b11);
      redir  = (src == 2'b01) || (src == 2'b10);
      exp_rv = !rst && !m_out && !m_held && !stall;
      exp_iv = !rst && m_held && !stall;

      chk("pc", bus.pc, m_pc);
      chk("req_valid", bus.imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("if_valid", bus.if_valid, exp_iv);
      chk("if_pc", bus.if_pc, m_if_pc);
      chk("if_instr", bus.if_instr, m_if_instr);
      chk("misalign", bus.fetch_misalign, m_mis);

      // Memory reacts to what the DUT actually presents
      if (rsp_fire) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(0, 2);
        mem_data = imem_word(bus.imem_req_addr);
      end

      // Advance the model by one clock
      rdy = bus.imem_req_ready;
      if (rst) begin
        m_pc = RESET_PC; m_if_pc = '0; m_if_instr = '0; m_mis = 0;
        m_out = 0; m_stale = 0; m_held = 0;
      end else begin
        logic [31:0] pc_now;
        pc_now = m_pc;
        m_mis  = redir && (npc[1:0] != 2'b00);
        if (redir) m_pc = {npc[31:2], 2'b00};
        if (m_held) begin
          if (redir) m_held = 0;
          else if (bus.if_ready && src == 2'b00) begin
            m_held = 0;
            m_pc   = npc;
          end
        end else if (m_out) begin
          if (rsp_fire) begin
            m_out = 0;
            if (!m_stale && !redir) begin
              m_held     = 1;
              m_if_pc    = pc_now;
              m_if_instr = imem_word(pc_now);
            end
          end else if (redir) begin
            m_stale = 1;
          end
        end else if (!stall && rdy) begin
          m_out   = 1;
          m_stale = redir;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
